// File: rtl/multi_digit_led_driver_if.sv
// -----------------------------------------------------------------------------
// multi_digit_led_driver_if
//   Bundles the data-load handshake and the display pins of the multi-digit
//   seven-segment driver.
//
//   Load handshake: the requester drives data_in/dp_in/blank_in and raises
//   load for one cycle; the values are taken on that clk edge with no
//   back-pressure, so load is always accepted. A later load before the
//   display picks the values up simply replaces them. load_ack pulses for
//   one cycle, together with frame_done, when the most recently loaded
//   values become the ones the display shows.
//
//   Signals:
//     data_in    [4*NUM_DIGITS] hex nibbles, digit k = bits [4k+3:4k]
//     dp_in      [NUM_DIGITS]   decimal point per digit, 1 = lit
//     blank_in   [NUM_DIGITS]   1 = digit dark
//     load                      one-cycle capture request
//     load_ack                  one-cycle pulse, loaded values now visible
//     frame_done                one-cycle pulse after the last digit slot
//     an         [NUM_DIGITS]   anodes, active low
//     seg        [7]            {a,b,c,d,e,f,g}, active low
//     dp                        decimal point, active low
//
//   Modports: master = data source / board side, slave = the driver.
// -----------------------------------------------------------------------------
interface multi_digit_led_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic                    load_ack;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  modport master (
    output data_in, dp_in, blank_in, load,
    input  load_ack, frame_done, an, seg, dp
  );

  modport slave (
    input  data_in, dp_in, blank_in, load,
    output load_ack, frame_done, an, seg, dp
  );
endinterface

// File: rtl/multi_digit_led_driver.sv
// -----------------------------------------------------------------------------
// multi_digit_led_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A clock-enable style slot counter divides the system clock into digit
//   slots; each slot starts with BLANK_CYCLES of all-anodes-off to stop
//   ghosting. New digit values are staged on load and only copied into the
//   displayed (shadow) copy at the frame boundary, so a frame never tears.
//
//   Parameters:
//     NUM_DIGITS   digits scanned, 2..8
//     TICK_DIV     clk cycles per digit slot, >= 2
//     BLANK_CYCLES cycles at slot start with anodes off, < TICK_DIV
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    multi_digit_led_driver_if.slave (load handshake + display pins)
//
//   Optional build macro LEADING_ZERO_BLANK_EN: when defined, leading zero
//   digits (nibble 0 and dp 0 for the digit and every more-significant one)
//   are darkened; digit 0 always shows.
// -----------------------------------------------------------------------------
module multi_digit_led_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 20000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  multi_digit_led_driver_if.slave    bus
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;

  logic [DW-1:0]         stage_data;
  logic [NUM_DIGITS-1:0] stage_dp;
  logic [NUM_DIGITS-1:0] stage_blank;
  logic                  pending;

  logic [DW-1:0]         shadow_data;
  logic [NUM_DIGITS-1:0] shadow_dp;
  // Effective blanking: blank_in plus any leading-zero suppression.
  logic [NUM_DIGITS-1:0] shadow_blank;

  logic                  boundary;
  logic                  in_blank;

  logic [DW-1:0]         src_data;
  logic [NUM_DIGITS-1:0] src_dp;
  logic [NUM_DIGITS-1:0] src_blank;
  logic [NUM_DIGITS-1:0] lz_mask;

  logic [3:0]            cur_nibble;

  assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

  // Anti-ghosting window at the start of each slot. A zero-length window
  // gets its own branch so no always-false compare is elaborated.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
      assign in_blank = (cnt < BLANK_END);
    end
  endgenerate

  // A load on the boundary cycle itself bypasses staging.
  always_comb begin
    src_data  = stage_data;
    src_dp    = stage_dp;
    src_blank = stage_blank;
    if (bus.load) begin
      src_data  = bus.data_in;
      src_dp    = bus.dp_in;
      src_blank = bus.blank_in;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic all_zero;

  // Walk from the most-significant digit down; a digit is suppressed while
  // it and everything above it is a zero nibble with no decimal point.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero && (src_data[4*k +: 4] == 4'h0) && !src_dp[k];
      lz_mask[k] = all_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Slot counter, digit index and the frame-synchronous load handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= '0;
      pending        <= 1'b0;
      stage_data     <= '0;
      stage_dp       <= '0;
      stage_blank    <= '0;
      shadow_data    <= '0;
      shadow_dp      <= '0;
      shadow_blank   <= '0;
      bus.load_ack   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      bus.frame_done <= boundary;
      bus.load_ack   <= boundary && (pending || bus.load);

      if (boundary) begin
        if (pending || bus.load) begin
          shadow_data  <= src_data;
          shadow_dp    <= src_dp;
          shadow_blank <= src_blank | lz_mask;
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        stage_data  <= bus.data_in;
        stage_dp    <= bus.dp_in;
        stage_blank <= bus.blank_in;
        pending     <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0000100;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  assign cur_nibble = shadow_data[{idx, 2'b00} +: 4];

  // Pin drive, registered one cycle behind the counter/index state. Only
  // the current digit's anode can be low, so at most one is ever on.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an  <= '1;
      bus.seg <= 7'b1111111;
      bus.dp  <= 1'b1;
    end else if (in_blank || shadow_blank[idx]) begin
      bus.an  <= '1;
      bus.seg <= 7'b1111111;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(NUM_DIGITS'(1) << idx);
      bus.seg <= decode(cur_nibble);
      bus.dp  <= ~shadow_dp[idx];
    end
  end

endmodule

// File: tb/tb_multi_digit_led_driver.sv
// -----------------------------------------------------------------------------
// tb_multi_digit_led_driver
//   Bench for multi_digit_led_driver with NUM_DIGITS=4, TICK_DIV=8,
//   BLANK_CYCLES=2. A reference model tracks time as a phase count since
//   reset and derives slot/digit/frame boundary from it arithmetically; it
//   keeps the staged and displayed values and pushes the expected pin vector
//   {an, seg, dp, load_ack, frame_done} for every clock into exp_q.
//   Build with +define+LEADING_ZERO_BLANK_EN to check the suppression option.
// -----------------------------------------------------------------------------
module tb_multi_digit_led_driver;
  localparam int N     = 4;
  localparam int TD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * TD;
  localparam int W     = N + 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multi_digit_led_driver_if #(.NUM_DIGITS(N)) bus ();

  multi_digit_led_driver #(
    .NUM_DIGITS  (N),
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int              phase;
  logic [4*N-1:0]  m_shadow_data, m_stage_data;
  logic [N-1:0]    m_shadow_dp, m_stage_dp;
  logic [N-1:0]    m_shadow_blank, m_stage_blank;
  bit              m_pending;

  logic [6:0] seg_table [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [W-1:0] observed();
    return {bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done};
  endfunction

  task automatic model_commit(input logic [4*N-1:0] d, input logic [N-1:0] p,
                              input logic [N-1:0] b);
    m_shadow_data  = d;
    m_shadow_dp    = p;
    m_shadow_blank = b;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < N; k++)
      if (((d >> (4 * k)) == 0) && ((p >> k) == 0)) m_shadow_blank[k] = 1'b1;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.load = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    phase = 0;
    m_shadow_data = '0; m_shadow_dp = '0; m_shadow_blank = '0;
    m_stage_data  = '0; m_stage_dp  = '0; m_stage_blank  = '0;
    m_pending = 1'b0;
    exp_q.delete();
  endtask

  // Driver: one clock of stimulus plus the model's prediction for it.
  task automatic tick(input bit ld, input logic [4*N-1:0] d,
                      input logic [N-1:0] p, input logic [N-1:0] b);
    int slot, digit;
    bit boundary;
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dp;
    slot     = phase % TD;
    digit    = (phase / TD) % N;
    boundary = (phase % FRAME) == FRAME - 1;
    e_an = '1; e_seg = 7'b1111111; e_dp = 1'b1;
    if (slot >= BC && !m_shadow_blank[digit]) begin
      e_an[digit] = 1'b0;
      e_seg = seg_table[m_shadow_data[4*digit +: 4]];
      e_dp  = ~m_shadow_dp[digit];
    end
    exp_q.push_back({e_an, e_seg, e_dp, boundary && (m_pending || ld), boundary});
    if (boundary) begin
      if (ld) model_commit(d, p, b);
      else if (m_pending) model_commit(m_stage_data, m_stage_dp, m_stage_blank);
      m_pending = 1'b0;
    end else if (ld) begin
      m_stage_data = d; m_stage_dp = p; m_stage_blank = b;
      m_pending = 1'b1;
    end
    phase++;
    bus.data_in = d; bus.dp_in = p; bus.blank_in = b; bus.load = ld;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    bus.data_in = '0; bus.dp_in = '0; bus.blank_in = '0;
    do_reset();
    n_total++; if (bus.an !== 4'b1111) $display("FAIL reset_an got=%b exp=1111", bus.an); else n_pass++;
    n_total++; if (bus.seg !== 7'b1111111) $display("FAIL reset_seg got=%b exp=1111111", bus.seg); else n_pass++;
    n_total++; if (bus.dp !== 1'b1) $display("FAIL reset_dp got=%b exp=1", bus.dp); else n_pass++;
    n_total++; if (bus.load_ack !== 1'b0) $display("FAIL reset_load_ack got=%b exp=0", bus.load_ack); else n_pass++;
    n_total++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); else n_pass++;
  endtask

  task automatic test_idle_scan();
    logic [W-1:0] e, g;
    int lit0 = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e) $display("FAIL idle_scan phase=%0d got=%h exp=%h", phase, g, e);
      else n_pass++;
      if (bus.an === 4'b1110) lit0++;
    end
    n_total++; if (lit0 !== TD - BC) $display("FAIL idle_digit0_lit got=%0d exp=%0d", lit0, TD - BC); else n_pass++;
  endtask

  task automatic test_load_midframe();
    logic [W-1:0] e, g;
    logic [6:0] seg_seen [N];
    logic dp2_seen = 1'b1;
    int acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL midframe_pre phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
    end
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (i == 0) tick(1'b1, 16'h1A3F, 4'b0100, 4'b0000);
      else        tick(1'b0, 16'h0000, 4'b0000, 4'b0000);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL midframe phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
      if (bus.load_ack === 1'b1) acks++;
      for (int k = 0; k < N; k++)
        if (bus.an[k] === 1'b0) begin
          seg_seen[k] = bus.seg;
          if (k == 2) dp2_seen = bus.dp;
        end
    end
    n_total++; if (acks !== 1) $display("FAIL midframe_acks got=%0d exp=1", acks); else n_pass++;
    n_total++; if (seg_seen[0] !== 7'b0111000) $display("FAIL midframe_d0 got=%b exp=0111000", seg_seen[0]); else n_pass++;
    n_total++; if (seg_seen[1] !== 7'b0000110) $display("FAIL midframe_d1 got=%b exp=0000110", seg_seen[1]); else n_pass++;
    n_total++; if (seg_seen[2] !== 7'b0001000) $display("FAIL midframe_d2 got=%b exp=0001000", seg_seen[2]); else n_pass++;
    n_total++; if (seg_seen[3] !== 7'b1001111) $display("FAIL midframe_d3 got=%b exp=1001111", seg_seen[3]); else n_pass++;
    n_total++; if (dp2_seen !== 1'b0) $display("FAIL midframe_dp2 got=%b exp=0", dp2_seen); else n_pass++;
  endtask

  task automatic test_double_load();
    logic [W-1:0] e, g;
    logic [6:0] seg0 = 7'h00;
    int acks = 0;
    while (phase % FRAME != 3) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL double_align phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 0)      tick(1'b1, 16'h1111, '0, '0);
      else if (i == 9) tick(1'b1, 16'h2222, '0, '0);
      else             tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL double_load phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
      if (bus.load_ack === 1'b1) acks++;
      if (bus.an === 4'b1110) seg0 = bus.seg;
    end
    n_total++; if (acks !== 1) $display("FAIL double_acks got=%0d exp=1", acks); else n_pass++;
    n_total++; if (seg0 !== 7'b0010010) $display("FAIL double_value got=%b exp=0010010", seg0); else n_pass++;
  endtask

  task automatic test_boundary_load();
    logic [W-1:0] e, g;
    logic [15:0] d;
    d = 16'($urandom);
    while (phase % FRAME != FRAME - 1) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL boundary_align phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
    end
    tick(1'b1, d, 4'($urandom), '0);
    e = exp_q.pop_front(); g = observed();
    n_total++; if (g !== e) $display("FAIL boundary_cycle got=%h exp=%h", g, e); else n_pass++;
    n_total++;
    if ({bus.load_ack, bus.frame_done} !== 2'b11)
      $display("FAIL boundary_ack_with_done got=%b exp=11", {bus.load_ack, bus.frame_done});
    else n_pass++;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL boundary_after phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
    end
  endtask

  task automatic test_blank();
    logic [W-1:0] e, g;
    int low [N];
    int done = 0;
    for (int k = 0; k < N; k++) low[k] = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == 0) tick(1'b1, 16'($urandom) | 16'h1111, 4'($urandom), 4'b1010);
      else        tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL blank phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
      if (i >= FRAME) begin
        for (int k = 0; k < N; k++) if (bus.an[k] === 1'b0) low[k]++;
        if (bus.frame_done === 1'b1) done++;
      end
    end
    n_total++; if (low[1] !== 0) $display("FAIL blank_an1 got=%0d exp=0", low[1]); else n_pass++;
    n_total++; if (low[3] !== 0) $display("FAIL blank_an3 got=%0d exp=0", low[3]); else n_pass++;
    n_total++; if (low[0] !== 2 * (TD - BC)) $display("FAIL blank_an0 got=%0d exp=%0d", low[0], 2 * (TD - BC)); else n_pass++;
    n_total++; if (done !== 2) $display("FAIL blank_period got=%0d exp=2", done); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] e, g;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 9) == 0)
        tick(1'b1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
      else
        tick(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL random phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] e, g;
    int acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) tick(1'b1, 16'h8888, 4'b1111, '0);
      else        tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL rst_mid_pre phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
    end
    do_reset();
    n_total++; if (bus.an !== 4'b1111) $display("FAIL rst_mid_an got=%b exp=1111", bus.an); else n_pass++;
    n_total++; if (bus.load_ack !== 1'b0) $display("FAIL rst_mid_ack got=%b exp=0", bus.load_ack); else n_pass++;
    for (int i = 0; i < FRAME + TD; i++) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL rst_mid_after phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
      if (bus.load_ack === 1'b1) acks++;
    end
    n_total++; if (acks !== 0) $display("FAIL rst_mid_discard got=%0d exp=0", acks); else n_pass++;
  endtask

  task automatic test_leading_zero();
    logic [W-1:0] e, g;
    int low [N];
    for (int k = 0; k < N; k++) low[k] = 0;
    tick(1'b1, 16'h0042, 4'b0000, 4'b0000);
    e = exp_q.pop_front(); g = observed();
    n_total++; if (g !== e) $display("FAIL lz_load got=%h exp=%h", g, e); else n_pass++;
    while (phase % FRAME != 0) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL lz_align phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
    end
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, '0, '0, '0);
      e = exp_q.pop_front(); g = observed();
      n_total++; if (g !== e) $display("FAIL lz_frame phase=%0d got=%h exp=%h", phase, g, e); else n_pass++;
      for (int k = 0; k < N; k++) if (bus.an[k] === 1'b0) low[k]++;
    end
    n_total++; if (low[0] !== TD - BC) $display("FAIL lz_an0 got=%0d exp=%0d", low[0], TD - BC); else n_pass++;
    n_total++; if (low[1] !== TD - BC) $display("FAIL lz_an1 got=%0d exp=%0d", low[1], TD - BC); else n_pass++;
`ifdef LEADING_ZERO_BLANK_EN
    n_total++; if (low[2] !== 0) $display("FAIL lz_an2 got=%0d exp=0", low[2]); else n_pass++;
    n_total++; if (low[3] !== 0) $display("FAIL lz_an3 got=%0d exp=0", low[3]); else n_pass++;
`else
    n_total++; if (low[2] !== TD - BC) $display("FAIL lz_an2 got=%0d exp=%0d", low[2], TD - BC); else n_pass++;
    n_total++; if (low[3] !== TD - BC) $display("FAIL lz_an3 got=%0d exp=%0d", low[3], TD - BC); else n_pass++;
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.load = 1'b0;
    bus.data_in = '0;
    bus.dp_in = '0;
    bus.blank_in = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_idle_scan();
    test_load_midframe();
    test_double_load();
    test_boundary_load();
    test_blank();
    test_random();
    test_reset_midframe();
    test_leading_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
